// File: rtl/descrambler_pkg.sv
// descrambler_pkg: scrambler polynomial constants shared by TX and RX, plus lock state encoding
package descrambler_pkg;
   localparam int SR_LEN = 20;
   localparam int TAP_A  = 2;
   localparam int TAP_B  = 19;
   localparam int FILL_W = $clog2(SR_LEN + 1);
   typedef enum logic {FLUSH = 1'b0, LOCK = 1'b1} lock_state_t;
endpackage

// File: rtl/descrambler_if.sv
// descrambler_if: received bitstream in, descrambled bitstream and lock status out
interface descrambler_if;
   logic data_in;
   logic bit_stb;
   logic sync_clr;
   logic data_out;
   logic data_valid;
   logic locked;
   modport master (output data_in, bit_stb, sync_clr, input data_out, data_valid, locked);
   modport slave  (input data_in, bit_stb, sync_clr, output data_out, data_valid, locked);
endinterface

// File: rtl/descrambler_strobe_watchdog.sv
// strobe_watchdog: pulses o_timeout after TIMEOUT consecutive clocks without a strobe
module strobe_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_stb,
   input  logic i_clr,
   output logic o_timeout
);
   localparam int W = $clog2(TIMEOUT);
   logic [W-1:0] r_idle;
   logic         w_expired;
   assign w_expired = r_idle == W'(TIMEOUT - 1);
   // a strobe arriving on the expiry cycle wins over the timeout
   assign o_timeout = w_expired && !i_stb && !i_clr;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_idle <= '0;
      else
         r_idle <= (i_stb || i_clr || w_expired) ? '0 : r_idle + 1'b1;
   end
endmodule

// File: rtl/descrambler.sv
// descrambler: self-synchronising x^3+x^20 descrambler with flush/lock tracking
module descrambler
   import descrambler_pkg::*;
#(
   parameter int IDLE_TIMEOUT = 1024
) (
   input logic         CLK,
   input logic         RESET_N,
   descrambler_if.slave bus
);
   logic [SR_LEN-1:0] r_hist;
   logic [FILL_W-1:0] r_fill;
   lock_state_t       r_state;
   lock_state_t       w_state_nx;
   logic              r_data_out;
   logic              r_data_valid;
   logic              w_timeout;
   logic              w_clr;
   logic              w_shift;
   strobe_watchdog #(.TIMEOUT(IDLE_TIMEOUT)) u_watchdog (
      .i_clk     (CLK),
      .i_rst_n   (RESET_N),
      .i_stb     (bus.bit_stb),
      .i_clr     (bus.sync_clr),
      .o_timeout (w_timeout)
   );
   assign w_clr   = bus.sync_clr || w_timeout;
   assign w_shift = bus.bit_stb && !bus.sync_clr;
   always_comb begin
      w_state_nx = r_state;
      w_state_nx = w_clr ? FLUSH : (w_shift && r_fill == FILL_W'(SR_LEN - 1)) ? LOCK : r_state;
   end
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         r_state <= FLUSH;
      else
         r_state <= w_state_nx;
   end
   // valid only once the history holds SR_LEN real bits, judged before this strobe counts
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_hist       <= '0;
         r_fill       <= '0;
         r_data_out   <= 1'b0;
         r_data_valid <= 1'b0;
      end else begin
         r_data_valid <= w_shift && r_fill == FILL_W'(SR_LEN);
         if (w_clr) begin
            r_hist <= '0;
            r_fill <= '0;
         end else if (w_shift) begin
            r_hist     <= {r_hist[SR_LEN-2:0], bus.data_in};
            r_data_out <= ~(bus.data_in ^ r_hist[TAP_A] ^ r_hist[TAP_B]);
            if (r_fill != FILL_W'(SR_LEN))
               r_fill <= r_fill + 1'b1;
         end
      end
   end
   assign bus.data_out   = r_data_out;
   assign bus.data_valid = r_data_valid;
   assign bus.locked     = r_state == LOCK;
endmodule

// File: tb/tb_descrambler.sv
// tb_descrambler: directed + random stimulus against a list-based reference of received bits
module tb_descrambler;
   localparam int T = 1024;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   descrambler_if bus ();
   descrambler #(.IDLE_TIMEOUT(T)) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );
   always #5 clk = ~clk;
   int n_cmp = 0;
   int n_fail = 0;
   bit rx[$];
   bit sc[$];
   bit m_out, m_valid, m_locked;
   int m_idle;
   function automatic bit hb(input int k);
      return (k < 0) ? 1'b0 : rx[k];
   endfunction
   function automatic bit sb(input int k);
      return (k < 0) ? 1'b0 : sc[k];
   endfunction
   task automatic model_reset();
      rx.delete();
      m_out = 0;
      m_valid = 0;
      m_locked = 0;
      m_idle = 0;
   endtask
   task automatic chk(input string tag, input logic got, input logic exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask
   task automatic check_all(input string tag);
      chk({tag, ".data_out"}, bus.data_out, m_out);
      chk({tag, ".data_valid"}, bus.data_valid, m_valid);
      chk({tag, ".locked"}, bus.locked, m_locked);
   endtask
   task automatic step(input string tag, input bit stb, input bit d, input bit clr);
      int n;
      @(negedge clk);
      bus.bit_stb = stb;
      bus.data_in = d;
      bus.sync_clr = clr;
      if (clr) begin
         rx.delete();
         m_valid = 0;
         m_locked = 0;
         m_idle = 0;
      end else if (stb) begin
         n = rx.size();
         m_valid = n >= 20;
         m_out = ~(d ^ hb(n - 3) ^ hb(n - 20));
         rx.push_back(d);
         m_locked = rx.size() >= 20;
         m_idle = 0;
      end else begin
         m_valid = 0;
         m_idle++;
         if (m_idle == T) begin
            rx.delete();
            m_locked = 0;
            m_idle = 0;
         end
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask
   initial begin
      bit src, s;
      bus.bit_stb = 0;
      bus.data_in = 0;
      bus.sync_clr = 0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1;
      for (int i = 1; i <= 25; i++) begin
         step("t1_zeros", 1, 0, 0);
         chk("t1_locked", bus.locked, i >= 20);
         chk("t1_valid", bus.data_valid, i >= 21);
         if (i >= 21) chk("t1_out_one", bus.data_out, 1'b1);
      end
      for (int i = 0; i < 10; i++) step("t2_ones", 1, 1, 0);
      step("t3_clr", 0, 0, 1);
      sc.delete();
      for (int k = 0; k < 1000; k++) begin
         src = 1'($urandom);
         s = ~(src ^ sb(k - 3) ^ sb(k - 20));
         sc.push_back(s);
         step("t3_loop", 1, s, 0);
         if (k >= 20) chk("t3_loopback", bus.data_out, src);
      end
      repeat (T - 1) step("t4_idle", 0, 0, 0);
      step("t4_edge_stb", 1, 1'($urandom), 0);
      chk("t4_edge_locked", bus.locked, 1'b1);
      repeat (T) step("t4_idle2", 0, 0, 0);
      chk("t4_dropped", bus.locked, 1'b0);
      for (int i = 1; i <= 21; i++) begin
         step("t4_relock", 1, 1'($urandom), 0);
         chk("t4_relock_valid", bus.data_valid, i == 21);
      end
      step("t5_clr_stb", 1, 1, 1);
      chk("t5_locked", bus.locked, 1'b0);
      chk("t5_valid", bus.data_valid, 1'b0);
      for (int i = 1; i <= 21; i++) begin
         step("t5_relock", 1, 1'($urandom), 0);
         chk("t5_relock_locked", bus.locked, i >= 20);
      end
      for (int i = 0; i < 5; i++) step("t6_pre", 1, 1'($urandom), 0);
      bus.bit_stb = 0;
      @(posedge clk);
      #3;
      rst_n = 0;
      model_reset();
      #1;
      check_all("t6_async_reset");
      @(negedge clk);
      rst_n = 1;
      for (int i = 1; i <= 21; i++) begin
         step("t6_refill", 1, 1'($urandom), 0);
         chk("t6_refill_valid", bus.data_valid, i == 21);
      end
      step("t6_tail", 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
